// File: rtl/player_position_if.sv
// Move-state/strobe inputs from the vector stage and position/edge outputs to the renderer.
interface player_position_if;
  logic       game_active;
  logic [3:0] player_move_hor_state;
  logic [3:0] player_move_vert_state;
  logic       clock_player_move_hor;
  logic       clock_player_move_vert;
  logic [6:0] player_x;
  logic [5:0] player_y;
  logic       player_at_left_edge;
  logic       player_at_right_edge;
  logic       player_at_top_edge;
  logic       player_at_bot_edge;
  logic       player_moved;

  modport master (
    output game_active, player_move_hor_state, player_move_vert_state,
           clock_player_move_hor, clock_player_move_vert,
    input  player_x, player_y, player_at_left_edge, player_at_right_edge,
           player_at_top_edge, player_at_bot_edge, player_moved
  );

  modport slave (
    input  game_active, player_move_hor_state, player_move_vert_state,
           clock_player_move_hor, clock_player_move_vert,
    output player_x, player_y, player_at_left_edge, player_at_right_edge,
           player_at_top_edge, player_at_bot_edge, player_moved
  );
endinterface

// File: rtl/player_position.sv
// Integrates per-axis step strobes into a saturating sprite position on the 96x64 OLED,
// with edge flags fed back to the vector stage.
module player_position #(
  parameter int unsigned SCREEN_W = 96,
  parameter int unsigned SCREEN_H = 64,
  parameter int unsigned PLAYER_W = 8,
  parameter int unsigned PLAYER_H = 8,
  parameter int unsigned SPAWN_X  = 44,
  parameter int unsigned SPAWN_Y  = 28,
  parameter int unsigned STEP     = 1
) (
  input logic              clock_100mhz,
  input logic              reset,
  player_position_if.slave pos
);

  localparam logic [7:0] XMax   = 8'(SCREEN_W - PLAYER_W);
  localparam logic [7:0] YMax   = 8'(SCREEN_H - PLAYER_H);
  localparam logic [7:0] Step   = 8'(STEP);
  localparam logic [6:0] SpawnX = 7'(SPAWN_X);
  localparam logic [5:0] SpawnY = 6'(SPAWN_Y);

  typedef enum logic [1:0] {StIdle, StStart, StActive} state_e;

  state_e     state_q, state_d;
  logic [6:0] x_q, x_d;
  logic [5:0] y_q, y_d;
  logic       moved_q, moved_d;
  logic       hor_prev_q, vert_prev_q;

  logic       hor_rise, vert_rise;
  logic       hor_left, hor_right, vert_up, vert_down;
  logic [7:0] x_wide, y_wide, x_step, y_step;

  // Saturating candidate positions; codes 6 and 13..15 leave the axis untouched.
  always_comb begin
    hor_rise  = pos.clock_player_move_hor & ~hor_prev_q;
    vert_rise = pos.clock_player_move_vert & ~vert_prev_q;
    hor_left  = pos.player_move_hor_state <= 4'd5;
    hor_right = (pos.player_move_hor_state >= 4'd7) && (pos.player_move_hor_state <= 4'd12);
    vert_up   = pos.player_move_vert_state <= 4'd5;
    vert_down = (pos.player_move_vert_state >= 4'd7) && (pos.player_move_vert_state <= 4'd12);
    x_wide    = {1'b0, x_q};
    y_wide    = {2'b00, y_q};
    x_step    = x_wide;
    y_step    = y_wide;
    if (hor_left) begin
      x_step = (x_wide < Step) ? 8'd0 : x_wide - Step;
    end else if (hor_right) begin
      x_step = (x_wide + Step > XMax) ? XMax : x_wide + Step;
    end
    if (vert_up) begin
      y_step = (y_wide < Step) ? 8'd0 : y_wide - Step;
    end else if (vert_down) begin
      y_step = (y_wide + Step > YMax) ? YMax : y_wide + Step;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    moved_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        x_d = SpawnX;
        y_d = SpawnY;
        if (pos.game_active) state_d = StStart;
      end
      StStart: begin
        x_d     = SpawnX;
        y_d     = SpawnY;
        state_d = StActive;
      end
      StActive: begin
        if (!pos.game_active) begin
          state_d = StIdle;
        end else begin
          if (hor_rise)  x_d = x_step[6:0];
          if (vert_rise) y_d = y_step[5:0];
          moved_d = (x_d != x_q) || (y_d != y_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // History resets high so a strobe already high out of reset is not taken as a step.
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      state_q     <= StIdle;
      x_q         <= SpawnX;
      y_q         <= SpawnY;
      moved_q     <= 1'b0;
      hor_prev_q  <= 1'b1;
      vert_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      moved_q     <= moved_d;
      hor_prev_q  <= pos.clock_player_move_hor;
      vert_prev_q <= pos.clock_player_move_vert;
    end
  end

  assign pos.player_x             = x_q;
  assign pos.player_y             = y_q;
  assign pos.player_moved         = moved_q;
  assign pos.player_at_left_edge  = (x_q == 7'd0);
  assign pos.player_at_right_edge = ({1'b0, x_q} == XMax);
  assign pos.player_at_top_edge   = (y_q == 6'd0);
  assign pos.player_at_bot_edge   = ({2'b00, y_q} == YMax);

endmodule

// File: tb/tb_player_position.sv
// Directed bench for player_position: stimulus pushes expected positions on each real move,
// a monitor pops and compares whenever player_moved pulses.
module tb_player_position;

  localparam int XMax = 88;
  localparam int YMax = 56;

  logic clock_100mhz = 1'b0;
  logic reset        = 1'b1;

  player_position_if pos ();

  player_position dut (
    .clock_100mhz (clock_100mhz),
    .reset        (reset),
    .pos          (pos)
  );

  always #5 clock_100mhz = ~clock_100mhz;

  int tests    = 0;
  int failures = 0;
  int mx       = 44;
  int my       = 28;
  logic [12:0] exp_q[$];

  task automatic chk(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock_100mhz);
    #1;
  endtask

  function automatic int next_coord(input int c, input logic [3:0] s, input int maxv);
    if (s <= 4'd5) return (c < 1) ? 0 : c - 1;
    if (s >= 4'd7 && s <= 4'd12) return (c + 1 > maxv) ? maxv : c + 1;
    return c;
  endfunction

  // One rising edge on the selected strobes, then back low.
  task automatic do_step(input bit dh, input bit dv);
    int nx, ny;
    nx = dh ? next_coord(mx, pos.player_move_hor_state, XMax) : mx;
    ny = dv ? next_coord(my, pos.player_move_vert_state, YMax) : my;
    if (nx != mx || ny != my) exp_q.push_back({7'(nx), 6'(ny)});
    mx = nx;
    my = ny;
    pos.clock_player_move_hor  = dh;
    pos.clock_player_move_vert = dv;
    tick();
    pos.clock_player_move_hor  = 1'b0;
    pos.clock_player_move_vert = 1'b0;
    tick();
  endtask

  task automatic check_pos(input string tag);
    @(negedge clock_100mhz);
    chk({tag, "_x"}, int'(pos.player_x), mx);
    chk({tag, "_y"}, int'(pos.player_y), my);
    chk({tag, "_left"}, int'(pos.player_at_left_edge), int'(mx == 0));
    chk({tag, "_right"}, int'(pos.player_at_right_edge), int'(mx == XMax));
    chk({tag, "_top"}, int'(pos.player_at_top_edge), int'(my == 0));
    chk({tag, "_bot"}, int'(pos.player_at_bot_edge), int'(my == YMax));
  endtask

  // Monitor: every player_moved pulse must match the oldest outstanding expectation.
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clock_100mhz);
      if (pos.player_moved === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_move: got x=%0d y=%0d, expected no move",
                   pos.player_x, pos.player_y);
        end else begin
          e = exp_q.pop_front();
          if ({pos.player_x, pos.player_y} !== e) begin
            failures++;
            $display("FAIL move_pos: got x=%0d y=%0d, expected x=%0d y=%0d",
                     pos.player_x, pos.player_y, e[12:6], e[5:0]);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    pos.game_active            = 1'b0;
    pos.player_move_hor_state  = 4'd6;
    pos.player_move_vert_state = 4'd6;
    pos.clock_player_move_hor  = 1'b0;
    pos.clock_player_move_vert = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_pos("reset");
    chk("reset_moved", int'(pos.player_moved), 0);

    // 1: idle with strobes toggling and a moving state selected
    pos.player_move_hor_state  = 4'd7;
    pos.player_move_vert_state = 4'd0;
    for (int i = 0; i < 20; i++) begin
      pos.clock_player_move_hor  = ~pos.clock_player_move_hor;
      pos.clock_player_move_vert = ~pos.clock_player_move_vert;
      tick();
    end
    pos.clock_player_move_hor  = 1'b0;
    pos.clock_player_move_vert = 1'b0;
    tick();
    check_pos("idle");

    // 2: start round, five right steps
    pos.player_move_vert_state = 4'd6;
    pos.game_active = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) do_step(1'b1, 1'b0);
    check_pos("right5");
    chk("right5_x_abs", int'(pos.player_x), 49);

    // 3: stopped horizontal state, strobe toggling every cycle
    pos.player_move_hor_state = 4'd6;
    for (int i = 0; i < 1000; i++) begin
      pos.clock_player_move_hor = ~pos.clock_player_move_hor;
      tick();
    end
    pos.player_move_hor_state = 4'd14;
    for (int i = 0; i < 20; i++) begin
      pos.clock_player_move_hor = ~pos.clock_player_move_hor;
      tick();
    end
    pos.clock_player_move_hor = 1'b0;
    tick();
    check_pos("stopped");

    // 4: walk to x=2, then four fastest-left steps saturating at 0
    pos.player_move_hor_state = 4'd0;
    for (int i = 0; i < 47; i++) do_step(1'b1, 1'b0);
    chk("at2_x", int'(pos.player_x), 2);
    for (int i = 0; i < 4; i++) begin
      do_step(1'b1, 1'b0);
      check_pos($sformatf("left_sat%0d", i));
    end

    // 5: diagonal to the bottom-right corner, then clamped
    pos.player_move_hor_state = 4'd12;
    for (int i = 0; i < 86; i++) do_step(1'b1, 1'b0);
    pos.player_move_hor_state  = 4'd6;
    pos.player_move_vert_state = 4'd12;
    for (int i = 0; i < 26; i++) do_step(1'b0, 1'b1);
    check_pos("at86_54");
    pos.player_move_hor_state = 4'd12;
    do_step(1'b1, 1'b1);
    check_pos("diag1");
    do_step(1'b1, 1'b1);
    check_pos("diag2");
    do_step(1'b1, 1'b1);
    check_pos("diag_clamp");

    // 6: reset coincident with a rising strobe at x=60
    pos.player_move_hor_state  = 4'd0;
    pos.player_move_vert_state = 4'd6;
    for (int i = 0; i < 28; i++) do_step(1'b1, 1'b0);
    chk("at60_x", int'(pos.player_x), 60);
    pos.player_move_hor_state = 4'd7;
    pos.clock_player_move_hor = 1'b1;
    reset = 1'b1;
    mx = 44;
    my = 28;
    tick();
    reset = 1'b0;
    check_pos("reset_mid");
    pos.clock_player_move_hor = 1'b0;
    tick();
    pos.clock_player_move_hor = 1'b1;
    tick();
    pos.clock_player_move_hor = 1'b0;
    tick();
    check_pos("post_reset_idle");
    tick();
    do_step(1'b1, 1'b0);
    check_pos("post_reset_step");

    // 7: dropping game_active returns to spawn
    pos.game_active = 1'b0;
    tick();
    tick();
    mx = 44;
    my = 28;
    check_pos("deactivate");

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
